// File: rtl/button_event_decoder.sv
// button_event_decoder: conditions a raw, bouncing push-button into a clean
// debounced level plus single-cycle press / release / click / long-press strobes.
// Pipeline: 2-FF synchronizer -> debounce filter -> press-classification FSM.
module button_event_decoder #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter bit BTN_ACTIVE_LOW    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_press_pulse
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    // The released pin level equals BTN_ACTIVE_LOW (high when active-low).
    localparam logic PIN_IDLE = BTN_ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } state_t;

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic raw;

    logic             level_q, level_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             accept;
    logic             rise;
    logic             fall;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              click_q, click_d;
    logic              long_q, long_d;

    // Synchronizer next-state: two flops in series, then polarity normalisation.
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        raw     = sync2_q ^ BTN_ACTIVE_LOW;
    end

    // Synchronizer registers; reset loads the released pin level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= PIN_IDLE;
            sync2_q <= PIN_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        accept    = 1'b0;
        if (raw == level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            level_d   = raw;
            deb_cnt_d = '0;
            accept    = 1'b1;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
        rise = accept & raw;
        fall = accept & ~raw;
    end

    // Debounce registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Classification FSM: strobes are decided on the same edge the debounced level
    // changes, so each strobe lines up with the first cycle of the new level.
    // A release on the long-threshold edge is checked first and therefore wins.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        click_d    = 1'b0;
        long_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    click_d   = 1'b1;
                    state_d   = IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            LONG: begin
                // hold_cnt is frozen here so it can never wrap on very long holds.
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, hold counter and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            click_q    <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            click_q    <= click_d;
            long_q     <= long_d;
        end
    end

    assign btn_level        = level_q;
    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign click_pulse      = click_q;
    assign long_press_pulse = long_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Testbench for button_event_decoder: directed stimulus with a scoreboard of
// expected events (cycle, strobes, level) checked by per-DUT monitors.
module tb_button_event_decoder;

    typedef struct {
        int         cyc;
        logic [3:0] stb;   // {press, release, click, long}
        logic       lvl;
    } ev_t;

    logic clk;
    logic rst;
    logic btn_a;
    logic btn_b;
    logic lvl_a, press_a, rel_a, click_a, long_a;
    logic lvl_b, press_b, rel_b, click_b, long_b;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    logic [3:0] stb_a;
    logic [3:0] stb_b;
    ev_t  e_a;
    ev_t  e_b;
    ev_t  sb_a[$];
    ev_t  sb_b[$];

    button_event_decoder #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(10),
        .BTN_ACTIVE_LOW   (1'b0)
    ) dut_a (
        .clk             (clk),
        .rst             (rst),
        .btn_in          (btn_a),
        .btn_level       (lvl_a),
        .press_pulse     (press_a),
        .release_pulse   (rel_a),
        .click_pulse     (click_a),
        .long_press_pulse(long_a)
    );

    button_event_decoder #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(10),
        .BTN_ACTIVE_LOW   (1'b1)
    ) dut_b (
        .clk             (clk),
        .rst             (rst),
        .btn_in          (btn_b),
        .btn_level       (lvl_b),
        .press_pulse     (press_b),
        .release_pulse   (rel_b),
        .click_pulse     (click_b),
        .long_press_pulse(long_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor A: every strobe or level change must match the head of the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            stb_a = {press_a, rel_a, click_a, long_a};
            if (stb_a != 4'b0000 || lvl_a != prev_a) begin
                tests++;
                if (sb_a.size() == 0) begin
                    fails++;
                    $display("FAIL a_unexpected cyc=%0d actual stb=%b lvl=%b required no event",
                             cyc, stb_a, lvl_a);
                end else begin
                    e_a = sb_a.pop_front();
                    if (e_a.cyc != cyc || e_a.stb != stb_a || e_a.lvl != lvl_a) begin
                        fails++;
                        $display("FAIL a_event actual cyc=%0d stb=%b lvl=%b required cyc=%0d stb=%b lvl=%b",
                                 cyc, stb_a, lvl_a, e_a.cyc, e_a.stb, e_a.lvl);
                    end
                end
            end
            prev_a = lvl_a;
        end
    end

    // Monitor B: same checking for the active-low instance.
    always @(negedge clk) begin
        if (mon_en) begin
            stb_b = {press_b, rel_b, click_b, long_b};
            if (stb_b != 4'b0000 || lvl_b != prev_b) begin
                tests++;
                if (sb_b.size() == 0) begin
                    fails++;
                    $display("FAIL b_unexpected cyc=%0d actual stb=%b lvl=%b required no event",
                             cyc, stb_b, lvl_b);
                end else begin
                    e_b = sb_b.pop_front();
                    if (e_b.cyc != cyc || e_b.stb != stb_b || e_b.lvl != lvl_b) begin
                        fails++;
                        $display("FAIL b_event actual cyc=%0d stb=%b lvl=%b required cyc=%0d stb=%b lvl=%b",
                                 cyc, stb_b, lvl_b, e_b.cyc, e_b.stb, e_b.lvl);
                    end
                end
            end
            prev_b = lvl_b;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_a(input int c, input logic [3:0] s, input logic l);
        ev_t e;
        e.cyc = c; e.stb = s; e.lvl = l;
        sb_a.push_back(e);
    endtask

    task automatic exp_b(input int c, input logic [3:0] s, input logic l);
        ev_t e;
        e.cyc = c; e.stb = s; e.lvl = l;
        sb_b.push_back(e);
    endtask

    // Hold button A for n cycles; p is the press-edge cycle, release falls at p+n.
    task automatic hold_a(input int n, input int long_at, input logic [3:0] rel_stb);
        int p;
        p = cyc + 6;
        exp_a(p, 4'b1000, 1'b1);
        if (long_at > 0) exp_a(p + long_at, 4'b0001, 1'b1);
        exp_a(p + n, rel_stb, 1'b0);
        btn_a = 1'b1;
        tick(n);
        btn_a = 1'b0;
        tick(20);
    endtask

    task automatic chk_rst(input string name, input logic [4:0] act);
        tests++;
        if (act !== 5'b00000) begin
            fails++;
            $display("FAIL %s actual=%b required=00000", name, act);
        end
    endtask

    int bounce[10] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 2};
    int p6;

    initial begin
        rst   = 1'b1;
        btn_a = 1'b0;
        btn_b = 1'b1;
        tick(3);
        chk_rst("reset_a", {lvl_a, press_a, rel_a, click_a, long_a});
        chk_rst("reset_b", {lvl_b, press_b, rel_b, click_b, long_b});
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(5);
        chk_rst("post_reset_a", {lvl_a, press_a, rel_a, click_a, long_a});
        chk_rst("post_reset_b", {lvl_b, press_b, rel_b, click_b, long_b});

        // 1. glitch of 3 cycles rejected, 4 cycles accepted
        btn_a = 1'b1;
        tick(3);
        btn_a = 1'b0;
        tick(15);
        hold_a(4, 0, 4'b0110);

        // 2. latency and click
        hold_a(8, 0, 4'b0110);

        // 3. long press
        hold_a(40, 10, 4'b0100);

        // 4. threshold race
        hold_a(10, 0, 4'b0110);
        hold_a(11, 10, 4'b0100);

        // 5. active-low bounce then stable press held 30 cycles
        for (int i = 0; i < 10; i++) begin
            btn_b = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(bounce[i]);
        end
        exp_b(cyc + 6, 4'b1000, 1'b1);
        exp_b(cyc + 16, 4'b0001, 1'b1);
        exp_b(cyc + 36, 4'b0100, 1'b0);
        btn_b = 1'b0;
        tick(30);
        btn_b = 1'b1;
        tick(20);

        // 6. reset in the middle of a held press
        p6 = cyc + 6;
        exp_a(p6, 4'b1000, 1'b1);
        btn_a = 1'b1;
        tick(10);
        exp_a(p6 + 5, 4'b0000, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_a(p6 + 11, 4'b1000, 1'b1);
        exp_a(p6 + 19, 4'b0110, 1'b0);
        tick(8);
        btn_a = 1'b0;
        tick(20);

        tests++;
        if (sb_a.size() != 0) begin
            fails++;
            $display("FAIL a_pending actual=%0d events left required=0", sb_a.size());
        end
        tests++;
        if (sb_b.size() != 0) begin
            fails++;
            $display("FAIL b_pending actual=%0d events left required=0", sb_b.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
